bs_rr_ctrl: RTL and testbench

Round-robin bus controller that shares a single packet bus among `DRVRS` driver FIFOs. It pops one packet at a time from a pending driver, decodes the 8-bit target field and pushes the packet into the destination driver(s), holding off while any destination is full. It sits between the per-driver input FIFOs (`pndng`/`pop`/`D_pop`) and the per-driver output FIFOs (`push`/`D_push`/`full`) of the bus system.

---
 rtl/bs_rr_ctrl.sv | 144 ++++++++++++++
 tb/tb_bs_rr_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bs_rr_ctrl.sv
// Round-robin packet bus controller: pops one packet from a pending driver FIFO and
// pushes it to the decoded destination(s). Define BS_RR_CTRL_BCAST_EN to enable broadcast delivery.
module bs_rr_ctrl #(
    parameter int          DRVRS     = 4,
    parameter int          PCKG_SZ   = 32,
    parameter logic [7:0]  BROADCAST = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DRVRS-1:0]                pndng,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]                pop,
    input  logic [DRVRS-1:0]                full,
    output logic [DRVRS-1:0]                push,
    output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
    output logic [DRVRS-1:0]                grant,
    output logic                            busy,
    output logic                            drop
);

    localparam int IW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    state_t               r_state;
    logic [IW-1:0]        r_last;
    logic [DRVRS-1:0]     r_grant;
    logic [PCKG_SZ-1:0]   r_pkt;
    logic [DRVRS-1:0]     r_dmask;

    logic                 w_found;
    logic [IW-1:0]        w_next_idx;
    logic [DRVRS-1:0]     w_next_grant;
    int                   w_dist;
    int                   w_best;

    logic [PCKG_SZ-1:0]   w_sel_pkt;
    logic [7:0]           w_tgt;
    logic [DRVRS-1:0]     w_dmask;
    logic                 w_push_go;

    // Pick the pending lane with the smallest rotational distance after r_last.
    always_comb begin
        w_found      = 1'b0;
        w_next_idx   = '0;
        w_best       = DRVRS;
        w_dist       = 0;
        w_next_grant = '0;
        for (int d = 0; d < DRVRS; d++) begin
            if (pndng[d]) begin
                w_dist = d - int'(r_last) - 1;
                if (w_dist < 0) w_dist = w_dist + DRVRS;
                if (w_dist < w_best) begin
                    w_best     = w_dist;
                    w_next_idx = IW'(d);
                    w_found    = 1'b1;
                end
            end
        end
        for (int d = 0; d < DRVRS; d++) begin
            w_next_grant[d] = w_found && (int'(w_next_idx) == d);
        end
    end

    assign w_sel_pkt = D_pop[r_last];
    assign w_tgt     = w_sel_pkt[PCKG_SZ-1 -: 8];

`ifdef BS_RR_CTRL_BCAST_EN
    logic [7:0] w_src;
    assign w_src = w_sel_pkt[PCKG_SZ-9 -: 8];
`endif

    always_comb begin
        w_dmask = '0;
        for (int d = 0; d < DRVRS; d++) begin
            if (int'(w_tgt) == d) w_dmask[d] = 1'b1;
        end
`ifdef BS_RR_CTRL_BCAST_EN
        if (w_tgt == BROADCAST) begin
            // A source outside the driver range matches no lane, so nothing is cleared.
            for (int d = 0; d < DRVRS; d++) begin
                w_dmask[d] = (int'(w_src) != d);
            end
        end
`else
        if (w_tgt == BROADCAST) w_dmask = '0;
`endif
    end

    // Delivery is all-or-nothing: every destination must have room in the same cycle.
    assign w_push_go = (r_state == PUSH) && (r_dmask != '0) && ((r_dmask & full) == '0);

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= IDLE;
            r_last  <= IW'(DRVRS - 1);
            r_grant <= '0;
            r_pkt   <= '0;
            r_dmask <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_next_grant;
                        r_last  <= w_next_idx;
                        r_state <= POP;
                    end
                end
                POP: begin
                    r_pkt   <= w_sel_pkt;
                    r_dmask <= w_dmask;
                    r_state <= PUSH;
                end
                PUSH: begin
                    if ((r_dmask == '0) || w_push_go) begin
                        r_grant <= '0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pop   = (r_state == POP) ? r_grant : '0;
        push  = w_push_go ? r_dmask : '0;
        grant = r_grant;
        busy  = (r_state != IDLE);
        drop  = (r_state == PUSH) && (r_dmask == '0);
        for (int d = 0; d < DRVRS; d++) begin
            D_push[d] = w_push_go ? r_pkt : '0;
        end
    end

endmodule

// File: tb/tb_bs_rr_ctrl.sv
// Scoreboard bench for bs_rr_ctrl: stimulus queues expected pops/pushes with cycle stamps,
// a negedge monitor compares them against the DUT.
module tb_bs_rr_ctrl;

    localparam int D = 4;
    localparam int W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [D-1:0]      pndng = '0;
    logic [D-1:0][W-1:0] d_pop = '0;
    logic [D-1:0]      pop;
    logic [D-1:0]      full = '0;
    logic [D-1:0]      push;
    logic [D-1:0][W-1:0] d_push;
    logic [D-1:0]      grant;
    logic              busy;
    logic              drop;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct { logic [D-1:0] mask; int cyc; } pop_exp_t;
    typedef struct { logic [D-1:0] push; logic drop; logic [W-1:0] data; int cyc; } out_exp_t;

    pop_exp_t exp_pop[$];
    out_exp_t exp_out[$];
    logic [W-1:0] fifo [D][$];

    bs_rr_ctrl #(.DRVRS(D), .PCKG_SZ(W), .BROADCAST(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop),
        .full(full), .push(push), .D_push(d_push), .grant(grant), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < D; i++) begin
            pndng[i] = (fifo[i].size() > 0);
            d_pop[i] = (fifo[i].size() > 0) ? fifo[i][0] : '0;
        end
    endtask

    task automatic load(input int lane, input logic [W-1:0] pkt);
        fifo[lane].push_back(pkt);
        refresh();
    endtask

    function automatic logic [W-1:0] mkpkt(input logic [7:0] t, input logic [7:0] s, input logic [15:0] p);
        return {t, s, p};
    endfunction

    task automatic exp_pkt(input logic [D-1:0] pmask, input int pcyc, input logic [D-1:0] omask,
                           input logic odrop, input logic [W-1:0] data, input int ocyc);
        pop_exp_t p;
        out_exp_t o;
        p.mask = pmask; p.cyc = pcyc;
        exp_pop.push_back(p);
        if (odrop || omask != '0) begin
            o.push = omask; o.drop = odrop; o.data = data; o.cyc = ocyc;
            exp_out.push_back(o);
        end
    endtask

    task automatic goto_pos(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_neg(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pop"},   pop,    '0);
        check({tag, "_push"},  push,   '0);
        check({tag, "_grant"}, grant,  '0);
        check({tag, "_busy"},  busy,   '0);
        check({tag, "_drop"},  drop,   '0);
        check({tag, "_dpush"}, d_push[0] | d_push[1] | d_push[2] | d_push[3], '0);
    endtask

    // Model FIFOs: dequeue on the pop strobe seen at the edge.
    always @(posedge clk) begin
        logic [D-1:0] p;
        p = pop;
        #1;
        for (int i = 0; i < D; i++) begin
            if (p[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        end
        refresh();
    end

    always @(negedge clk) begin
        pop_exp_t pe;
        out_exp_t oe;
        if (pop != '0) begin
            if (exp_pop.size() == 0) check("pop_unexpected", pop, '0);
            else begin
                pe = exp_pop.pop_front();
                check("pop_mask", pop, pe.mask);
                check("pop_cycle", cyc, pe.cyc);
            end
        end
        if (push != '0 || drop) begin
            if (exp_out.size() == 0) check("out_unexpected", {push, drop}, '0);
            else begin
                oe = exp_out.pop_front();
                check("out_push", push, oe.push);
                check("out_drop", drop, oe.drop);
                check("out_cycle", cyc, oe.cyc);
                if (oe.push != '0) begin
                    for (int i = 0; i < D; i++) check("out_data", d_push[i], oe.data);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] pk;
        int lane;

        // Reset state
        goto_neg(1); check_zero("rst1");
        goto_neg(2); check_zero("rst2");
        goto_pos(3); reset = 1'b0;

        // Single request: lane 1 -> target 3
        goto_pos(5);
        pk = 32'h0301_05A5;
        load(1, pk);
        exp_pkt(4'b0010, 6, 4'b1000, 1'b0, pk, 7);
        goto_neg(5); check("single_busy_idle", busy, 1'b0);
        goto_neg(6); check("single_busy_pop", busy, 1'b1); check("single_grant", grant, 4'b0010);
        goto_neg(7); check("single_busy_push", busy, 1'b1);
        goto_neg(8); check("single_busy_done", busy, 1'b0); check("single_grant_clr", grant, '0);

        // Fairness: two packets per lane, last grant was lane 1 so order is 2,3,0,1,...
        goto_pos(10);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < D; i++)
                load(i, mkpkt(8'((i + 1) % D), 8'(i), 16'(16'hA000 + r * 16 + i)));
        for (int n = 0; n < 8; n++) begin
            lane = (2 + n) % D;
            pk = mkpkt(8'((lane + 1) % D), 8'(lane), 16'(16'hA000 + (n / 4) * 16 + lane));
            exp_pkt(4'(1 << lane), 11 + 3 * n, 4'(1 << ((lane + 1) % D)), 1'b0, pk, 12 + 3 * n);
        end

        // Broadcast from source 2
        goto_pos(36);
        pk = 32'hFF02_1234;
        load(2, pk);
`ifdef BS_RR_CTRL_BCAST_EN
        exp_pkt(4'b0100, 37, 4'b1011, 1'b0, pk, 38);
`else
        exp_pkt(4'b0100, 37, 4'b0000, 1'b1, pk, 38);
`endif

        // Backpressure: full[1] high for 5 PUSH cycles; full[2] is not a destination
        goto_pos(40);
        full = 4'b0110;
        pk = 32'h0100_BEEF;
        load(0, pk);
        exp_pkt(4'b0001, 41, 4'b0010, 1'b0, pk, 47);
        for (int c = 42; c <= 46; c++) begin
            goto_neg(c);
            check("bp_hold_push", push, '0);
            check("bp_hold_busy", busy, 1'b1);
        end
        goto_pos(47);
        full = 4'b0100;

        // Loopback (1->1), invalid target 7, target == DRVRS
        goto_pos(50);
        load(3, 32'h0703_0007);
        load(0, 32'h0400_0004);
        load(1, 32'h0101_1111);
        exp_pkt(4'b0010, 51, 4'b0010, 1'b0, 32'h0101_1111, 52);
        exp_pkt(4'b1000, 54, 4'b0000, 1'b1, '0, 55);
        exp_pkt(4'b0001, 57, 4'b0000, 1'b1, '0, 58);
        goto_neg(59); check("inv_idle_busy", busy, 1'b0);

        // Reset while held in PUSH: packet is lost, then lane 0 wins first
        goto_pos(62);
        load(0, 32'h0200_CAFE);
        exp_pkt(4'b0001, 63, 4'b0000, 1'b0, '0, 0);
        goto_neg(64); check("mid_push_held", busy, 1'b1);
        goto_pos(65); reset = 1'b1;
        goto_neg(66); check_zero("mid_rst1");
        goto_neg(67); check_zero("mid_rst2");
        goto_pos(68);
        reset = 1'b0;
        full  = '0;
        for (int i = 0; i < D; i++) begin
            pk = mkpkt(8'(D - 1 - i), 8'(i), 16'(16'hC000 + i));
            load(i, pk);
            exp_pkt(4'(1 << i), 69 + 3 * i, 4'(1 << (D - 1 - i)), 1'b0, pk, 70 + 3 * i);
        end

        goto_pos(85);
        check("sb_pop_left", exp_pop.size(), 0);
        check("sb_out_left", exp_out.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
